// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy state encoding and per-stage control bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } pipe_state_t;

  // Decode/execute control bundle; width of this struct sets the stage CTRL_W.
  typedef struct packed {
    logic [3:0] alucontrol;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       we3;
    logic       we;
    logic       hilowrite;
    logic       memtoreg;
    logic       branch;
    logic       jump;
    logic [4:0] shamt;
    logic [5:0] funct;
  } de_ctrl_t;

  localparam int unsigned DE_CTRL_W = $bits(de_ctrl_t);
  localparam int unsigned DE_DATA_W = 48;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : clear to zero next cycle
//   inc_i      : add one unless already at all-ones
//   cnt_o      : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_register_elastic.sv
// Generic elastic pipeline stage: valid/ready handshake, synchronous flush,
// optional skid entry, control bus forced to zero while the stage is empty,
// and saturating stall/bubble performance counters.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake (in_ready registered when SKID=1)
//   in_data/in_ctrl      : upstream payload and control
//   flush                : drop every held entry and the current input
//   out_valid/out_ready  : downstream handshake
//   out_data/out_ctrl    : main-entry payload and control (ctrl zero when invalid)
//   cnt_clr              : clear both counters
//   stall_cnt/bubble_cnt : saturating stall and bubble cycle counts
module pipeline_register_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DE_DATA_W,
  parameter int unsigned CTRL_W = DE_CTRL_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state_q, state_d;
  logic              accept;
  logic              main_load, skid_load, main_from_skid;
  logic              valid_q;
  logic [DATA_W-1:0] data_q, data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, skid_ctrl_q, skid_ctrl_d;

  assign accept = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SKIDFULL is only reachable with a skid entry.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_d = FULL;
        end
        FULL: begin
          if (accept && !out_ready) begin
            state_d = (SKID != 0) ? SKIDFULL : FULL;
          end else if (!accept && out_ready) begin
            state_d = EMPTY;
          end
        end
        SKIDFULL: begin
          if (out_ready) state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry load controls; flush suppresses every load so the dropped input leaves no trace.
  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY:    main_load = accept;
        FULL: begin
          main_load = accept & out_ready;
          skid_load = accept & ~out_ready;
        end
        SKIDFULL: main_from_skid = out_ready;
        default:  ;
      endcase
    end
  end

  // Entry datapath; control is zeroed whenever the stage goes empty, payload is kept.
  always_comb begin
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (main_load) begin
      data_d = in_data;
      ctrl_d = in_ctrl;
    end else if (main_from_skid) begin
      data_d = skid_data_q;
      ctrl_d = skid_ctrl_q;
    end
    if (skid_load) begin
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end
    if (state_d == EMPTY) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      valid_q     <= (state_d != EMPTY);
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Upstream ready: registered from the next state with a skid entry, else combinational.
  if (SKID != 0) begin : g_skid
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != SKIDFULL);
      end
    end
    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign in_ready = out_ready | ~valid_q;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (valid_q & ~out_ready),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (~valid_q & out_ready),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Bench for the elastic stage: a SKID=1 and a SKID=0 instance share stimulus and are
// each checked every cycle against a FIFO-occupancy model, plus directed literal checks.
module tb_pipeline_register_elastic;

  localparam int unsigned DW   = 48;
  localparam int unsigned CW   = 24;
  localparam int unsigned CNTW = 4;
  localparam int          SAT  = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;

  logic [1:0]      o_valid, o_irdy;
  logic [DW-1:0]   o_data  [2];
  logic [CW-1:0]   o_ctrl  [2];
  logic [CNTW-1:0] o_stall [2];
  logic [CNTW-1:0] o_bub   [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_register_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(CNTW)) u_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_irdy[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(o_data[0]), .out_ctrl(o_ctrl[0]),
    .cnt_clr(cnt_clr), .stall_cnt(o_stall[0]), .bubble_cnt(o_bub[0])
  );

  pipeline_register_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(CNTW)) u_noskid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_irdy[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(o_data[1]), .out_ctrl(o_ctrl[1]),
    .cnt_clr(cnt_clr), .stall_cnt(o_stall[1]), .bubble_cnt(o_bub[1])
  );

  // Model: index 0 is the two-deep skid stage, index 1 the single-entry stage.
  int            m_n     [2];
  logic [DW-1:0] m_d     [2][2];
  logic [CW-1:0] m_c     [2][2];
  logic [DW-1:0] m_last  [2];
  int            m_stall [2];
  int            m_bub   [2];
  bit            m_rdy, m_vld;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_last[k] = '0; m_stall[k] = 0; m_bub[k] = 0;
    end
  end

  function automatic bit exp_rdy(int k);
    if (k == 0) return (m_n[0] < 2);
    return out_ready || (m_n[1] == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_rdy = exp_rdy(k);
      m_vld = (m_n[k] > 0);
      if (reset) begin
        m_n[k] = 0; m_last[k] = '0; m_stall[k] = 0; m_bub[k] = 0;
      end else begin
        if (cnt_clr) begin
          m_stall[k] = 0; m_bub[k] = 0;
        end else begin
          if (m_vld && !out_ready && m_stall[k] < SAT) m_stall[k]++;
          if (!m_vld && out_ready && m_bub[k] < SAT) m_bub[k]++;
        end
        if (flush) begin
          m_n[k] = 0;
        end else begin
          if (m_vld && out_ready) begin
            m_d[k][0] = m_d[k][1];
            m_c[k][0] = m_c[k][1];
            m_n[k]--;
          end
          if (in_valid && m_rdy) begin
            m_d[k][m_n[k]] = in_data;
            m_c[k][m_n[k]] = in_ctrl;
            m_n[k]++;
          end
          if (m_n[k] > 0) m_last[k] = m_d[k][0];
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d out_valid", k), 64'(o_valid[k]), 64'(m_n[k] > 0));
        chk($sformatf("dut%0d out_data", k), 64'(o_data[k]), 64'(m_last[k]));
        chk($sformatf("dut%0d out_ctrl", k), 64'(o_ctrl[k]), (m_n[k] > 0) ? 64'(m_c[k][0]) : 64'(0));
        chk($sformatf("dut%0d in_ready", k), 64'(o_irdy[k]), 64'(exp_rdy(k)));
        chk($sformatf("dut%0d stall_cnt", k), 64'(o_stall[k]), 64'(m_stall[k]));
        chk($sformatf("dut%0d bubble_cnt", k), 64'(o_bub[k]), 64'(m_bub[k]));
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit rdy, input bit fl, input bit clr, input bit rst);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
    cnt_clr   = clr;
    reset     = rst;
    #2;
  endtask

  initial begin
    drive(0, '0, '0, 0, 0, 0, 1);
    drive(0, '0, '0, 0, 0, 0, 1);
    chk_en = 1'b1;

    // Reset values, then stream 1,2,3.
    drive(1, 48'd1, 24'h000101, 0, 0, 0, 0);
    chk("reset out_valid", 64'(o_valid[0]), 64'd0);
    chk("reset out_data", 64'(o_data[0]), 64'd0);
    chk("reset out_ctrl", 64'(o_ctrl[0]), 64'd0);
    chk("reset in_ready skid", 64'(o_irdy[0]), 64'd1);
    chk("reset stall_cnt", 64'(o_stall[0]), 64'd0);
    drive(1, 48'd2, 24'h000202, 1, 0, 0, 0);
    chk("stream data1", 64'(o_data[0]), 64'd1);
    chk("stream ctrl1", 64'(o_ctrl[0]), 64'h000101);
    drive(1, 48'd3, 24'h000303, 1, 0, 0, 0);
    chk("stream data2 skid", 64'(o_data[0]), 64'd2);
    chk("stream data2 noskid", 64'(o_data[1]), 64'd2);
    drive(0, '0, '0, 0, 0, 0, 0);
    chk("stream data3", 64'(o_data[0]), 64'd3);
    chk("stream bubble_cnt", 64'(o_bub[0]), 64'd0);

    // Idle with downstream ready: five bubbles, control stays zero.
    drive(0, '0, '0, 1, 0, 0, 0);
    drive(0, '0, '0, 1, 0, 1, 0);
    chk("idle out_valid", 64'(o_valid[0]), 64'd0);
    chk("idle data held", 64'(o_data[0]), 64'd3);
    for (int i = 0; i < 5; i++) drive(0, '0, '0, 1, 0, 0, 0);
    drive(0, '0, '0, 0, 0, 0, 0);
    chk("idle bubble_cnt", 64'(o_bub[0]), 64'd5);
    chk("idle out_ctrl", 64'(o_ctrl[0]), 64'd0);

    // Stall with skid: A then B, three stall cycles, release.
    drive(0, '0, '0, 0, 0, 1, 0);
    drive(1, 48'hA0A0_A0A0_A0A0, 24'hAAAAAA, 0, 0, 0, 0);
    drive(1, 48'hB0B0_B0B0_B0B0, 24'hBBBBBB, 0, 0, 0, 0);
    chk("noskid in_ready comb", 64'(o_irdy[1]), 64'd0);
    drive(0, '0, '0, 0, 0, 0, 0);
    chk("skidfull in_ready", 64'(o_irdy[0]), 64'd0);
    chk("skidfull data A", 64'(o_data[0]), 64'hA0A0_A0A0_A0A0);
    drive(0, '0, '0, 0, 0, 0, 0);
    chk("noskid data held", 64'(o_data[1]), 64'hA0A0_A0A0_A0A0);
    drive(0, '0, '0, 1, 0, 0, 0);
    chk("release data A", 64'(o_data[0]), 64'hA0A0_A0A0_A0A0);
    drive(0, '0, '0, 1, 0, 0, 0);
    chk("release data B", 64'(o_data[0]), 64'hB0B0_B0B0_B0B0);
    chk("release ctrl B", 64'(o_ctrl[0]), 64'hBBBBBB);
    chk("stall_cnt length", 64'(o_stall[0]), 64'd3);
    drive(0, '0, '0, 1, 0, 0, 0);

    // Flush in SKIDFULL with C on the input.
    drive(1, 48'h1111_1111_1111, 24'h111111, 0, 0, 0, 0);
    drive(1, 48'h2222_2222_2222, 24'h222222, 0, 0, 0, 0);
    drive(1, 48'hCCCC_CCCC_CCCC, 24'hCCCCCC, 0, 1, 0, 0);
    drive(0, '0, '0, 1, 0, 0, 0);
    chk("flush out_valid", 64'(o_valid[0]), 64'd0);
    chk("flush out_ctrl", 64'(o_ctrl[0]), 64'd0);
    chk("flush in_ready", 64'(o_irdy[0]), 64'd1);
    drive(0, '0, '0, 1, 0, 0, 0);
    chk("flush C dropped", 64'(o_valid[0]), 64'd0);
    chk("flush data held", 64'(o_data[0]), 64'h1111_1111_1111);

    // Counter saturation over 20 stall cycles, then clear.
    drive(1, 48'hD, 24'h00000D, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) drive(0, '0, '0, 0, 0, 0, 0);
    drive(0, '0, '0, 0, 0, 1, 0);
    chk("stall_cnt saturated skid", 64'(o_stall[0]), 64'd15);
    chk("stall_cnt saturated noskid", 64'(o_stall[1]), 64'd15);
    drive(0, '0, '0, 1, 0, 0, 0);
    chk("stall_cnt cleared", 64'(o_stall[0]), 64'd0);

    // Randomized traffic with occasional flush, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, DW'({$urandom(), $urandom()}), CW'($urandom()),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1);
    end
    drive(0, '0, '0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_register_elastic.md
Name: pipeline_register_elastic

Overview:
- Parametrised successor to the fixed decode/execute stage register: one generic pipeline stage usable between any two stages (F/D, D/E, E/M, M/W).
- Carries a payload bus and a control bus with valid/ready handshake, stall back-pressure, synchronous flush (bubble insertion) and an optional skid entry for full throughput.
- Bubbles always present all-zero control, so downstream write enables (we3, we, hilowrite) can never fire spuriously. Also provides saturating stall and bubble counters for performance analysis.

Parameters:
- DATA_W, 48, payload width (e.g. rd1, rd2, signextimm concatenated); not cleared on bubble.
- CTRL_W, 24, control width (alucontrol, regwrite, we3, we, ...); forced to zero whenever the stage is invalid.
- SKID, 1, 0 = single-entry stage with combinational in_ready; 1 = two-entry skid stage with registered in_ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous kill of all held entries (branch/hazard flush).
- out_valid  out  1  stage presents a valid instruction.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_data  out  DATA_W  payload of the main entry.
- out_ctrl  out  CTRL_W  control of the main entry; zero when out_valid=0.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1, saturating.

Behaviour:
- Handshake: accept = in_valid & in_ready; transfer out = out_valid & out_ready. Latency 1 cycle from accept to out_valid when the stage was empty.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, skid entry empty, in_ready=1, stall_cnt=0, bubble_cnt=0.
- Bubble rule: out_ctrl = 0 whenever out_valid=0. out_data holds its last value.
- Priority: reset > flush > normal operation.
- Flush:
  - Next cycle out_valid=0 and the skid entry is empty.
  - An input arriving in the flush cycle is dropped.
  - in_ready=1 in the cycle after the flush.
  - Counters are unaffected.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept, the main entry loads the input.
  - On transfer without accept, out_valid goes to 0.
- SKID=1 state machine (EMPTY, FULL, SKIDFULL):
  - in_ready = (state != SKIDFULL), registered, with no combinational path from out_ready.
  - EMPTY: accept -> FULL, main loads input.
  - FULL: accept & out_ready -> FULL, main loads input.
  - FULL: accept & ~out_ready -> SKIDFULL, skid loads input and main holds.
  - FULL: ~accept & out_ready -> EMPTY.
  - FULL: otherwise hold.
  - SKIDFULL: out_ready -> FULL, main loads skid.
  - SKIDFULL: otherwise hold.
- Ordering: strict FIFO order; no entry is ever lost or duplicated except by flush.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 without wrapping.
  - cnt_clr takes priority over increment: the counter is 0 next cycle.
  - Counting is based on registered out_valid and the current out_ready.
- Reset mid-operation: all entries are discarded and the reset values apply next cycle. A simultaneous flush is irrelevant.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, FULL, SKIDFULL} pipe_state_t;
  - packed struct typedefs for each stage's control bundle (e.g. de_ctrl_t), so CTRL_W = $bits(de_ctrl_t).
- One natural sub-module: sat_counter (CNT_W, clr, inc), instantiated twice.

Test Plan:
- Reset then streaming: in_valid=1 with data 1,2,3, out_ready=1 -> out_data 1,2,3 on cycles 1,2,3; bubble_cnt=0.
- Stall with skid (SKID=1): load A, out_ready=0, present B -> state SKIDFULL, in_ready=0. Release out_ready -> outputs A then B; stall_cnt equals the stall length.
- Flush in SKIDFULL with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
- Idle downstream-ready with in_valid=0 for 5 cycles -> bubble_cnt=5, out_ctrl=0 throughout.
- Counter saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15. Then cnt_clr -> 0 next cycle.
- SKID=0 back-pressure: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; data held stable until out_ready=1.
